// File: rtl/predecode_queue.sv
// Instruction queue between fetch and decode. Each instruction is predecoded once, when it is enqueued.
// Latency: an enqueue into an empty queue shows out_valid on the next cycle. There is no same-cycle bypass.
// Backpressure: in_ready = !full, taken from registered pointers only. A dequeue does not free a slot in the same cycle.
module predecode_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_is_branch_jump,
    output logic              out_is_jump,
    output logic              out_is_jump_reg,
    output logic [ADDR_W-1:0] out_branch_target,
    output logic              out_uses_rs,
    output logic              out_uses_rt,
    output logic              out_uses_rw,
    output logic [4:0]        out_rs_addr,
    output logic [4:0]        out_rt_addr,
    output logic [4:0]        out_rw_addr,
    output logic              out_illegal,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
        logic              is_branch_jump;
        logic              is_jump;
        logic              is_jump_reg;
        logic [ADDR_W-1:0] target;
        logic              uses_rs;
        logic              uses_rt;
        logic              uses_rw;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        rw_addr;
        logic              illegal;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head_entry;
    logic [PTR_W-1:0] head, tail;
    logic             full, empty, enq, deq;

    logic [5:0] op, fn;
    logic [4:0] f_rs, f_rt, f_rd;
    logic       want_rs, want_rt, want_rw, is_br, is_jabs;
    logic [4:0] raw_rs, raw_rw;
    logic [31:0] jt32;

    assign op   = in_inst[31:26];
    assign f_rs = in_inst[25:21];
    assign f_rt = in_inst[20:16];
    assign f_rd = in_inst[15:11];
    assign fn   = in_inst[5:0];

    assign empty     = (head == tail);
    assign full      = (head[IDX_W] != tail[IDX_W]) && (head[IDX_W-1:0] == tail[IDX_W-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;
    assign count     = tail - head;

    // Classify the offered instruction: operand usage, control-flow kind and legality
    always_comb begin
        want_rs = 1'b0;
        want_rt = 1'b0;
        want_rw = 1'b0;
        raw_rs  = f_rs;
        raw_rw  = f_rd;
        is_br   = 1'b0;
        is_jabs = 1'b0;
        new_entry = '0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h04, 6'h06, 6'h07, 6'h2A, 6'h2B: begin
                        want_rs = 1'b1; want_rt = 1'b1; want_rw = 1'b1;
                    end
                    // constant shifts read rt, presented on the rs port
                    6'h00, 6'h02, 6'h03: begin
                        want_rs = 1'b1; raw_rs = f_rt; want_rw = 1'b1;
                    end
                    6'h08: begin
                        want_rs = 1'b1;
                        new_entry.is_branch_jump = 1'b1;
                        new_entry.is_jump        = 1'b1;
                        new_entry.is_jump_reg    = 1'b1;
                    end
                    6'h09: begin
                        want_rs = 1'b1; want_rw = 1'b1; raw_rw = 5'd31;
                        new_entry.is_branch_jump = 1'b1;
                        new_entry.is_jump        = 1'b1;
                        new_entry.is_jump_reg    = 1'b1;
                    end
                    default: new_entry.illegal = 1'b1;
                endcase
            end
            6'h01, 6'h06, 6'h07: begin want_rs = 1'b1; is_br = 1'b1; end
            6'h04, 6'h05: begin want_rs = 1'b1; want_rt = 1'b1; is_br = 1'b1; end
            6'h02: is_jabs = 1'b1;
            6'h03: begin is_jabs = 1'b1; want_rw = 1'b1; raw_rw = 5'd31; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h30: begin
                want_rs = 1'b1; want_rw = 1'b1; raw_rw = f_rt;
            end
            6'h0F: begin want_rw = 1'b1; raw_rw = f_rt; end
            6'h2B: begin want_rs = 1'b1; want_rt = 1'b1; end
            6'h38: begin want_rs = 1'b1; want_rt = 1'b1; want_rw = 1'b1; raw_rw = f_rt; end
            6'h10: begin
                if (f_rd == 5'h17 || f_rd == 5'h18 || f_rd == 5'h19) want_rt = 1'b1;
                else new_entry.illegal = 1'b1;
            end
            default: new_entry.illegal = 1'b1;
        endcase

        // absolute jump target keeps the top nibble of pc+4, with pc zero-extended to 32 bits
        jt32 = ((32'(in_pc) + 32'd4) & 32'hF000_0000) | {4'b0000, in_inst[25:0], 2'b00};

        new_entry.pc   = in_pc;
        new_entry.inst = in_inst;
        if (is_br) begin
            new_entry.is_branch_jump = 1'b1;
            new_entry.target = in_pc + ADDR_W'(32'd4)
                             + ADDR_W'({{14{in_inst[15]}}, in_inst[15:0], 2'b00});
        end
        if (is_jabs) begin
            new_entry.is_branch_jump = 1'b1;
            new_entry.is_jump        = 1'b1;
            new_entry.target         = ADDR_W'(jt32);
        end
        // register 0 never counts as a real operand, so usage and address both drop to 0
        new_entry.uses_rs = want_rs && (raw_rs != 5'd0);
        new_entry.uses_rt = want_rt && (f_rt != 5'd0);
        new_entry.uses_rw = want_rw && (raw_rw != 5'd0);
        new_entry.rs_addr = new_entry.uses_rs ? raw_rs : 5'd0;
        new_entry.rt_addr = new_entry.uses_rt ? f_rt   : 5'd0;
        new_entry.rw_addr = new_entry.uses_rw ? raw_rw : 5'd0;
    end

    // Entry storage: cleared on reset, written at the tail on enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq) begin
            mem[tail[IDX_W-1:0]] <= new_entry;
        end
    end

    // Head/tail pointers with wrap bit; a flush returns both to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
        end
    end

    // Present the head entry to decode
    always_comb begin
        head_entry         = mem[head[IDX_W-1:0]];
        out_pc             = head_entry.pc;
        out_inst           = head_entry.inst;
        out_is_branch_jump = head_entry.is_branch_jump;
        out_is_jump        = head_entry.is_jump;
        out_is_jump_reg    = head_entry.is_jump_reg;
        out_branch_target  = head_entry.target;
        out_uses_rs        = head_entry.uses_rs;
        out_uses_rt        = head_entry.uses_rt;
        out_uses_rw        = head_entry.uses_rw;
        out_rs_addr        = head_entry.rs_addr;
        out_rt_addr        = head_entry.rt_addr;
        out_rw_addr        = head_entry.rw_addr;
        out_illegal        = head_entry.illegal;
    end
endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue: hand-computed predecode vectors, FIFO order, full, wrap, flush and reset.
module tb_predecode_queue;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst, out_branch_target;
    logic        out_is_branch_jump, out_is_jump, out_is_jump_reg;
    logic        out_uses_rs, out_uses_rt, out_uses_rw, out_illegal;
    logic [4:0]  out_rs_addr, out_rt_addr, out_rw_addr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bj, j, jr;
        logic [31:0] tgt;
        logic        urs, urt, urw;
        logic [4:0]  rs, rt, rw;
        logic        ill;
    } exp_t;

    exp_t vec [14];
    exp_t sb [$];

    always #5 clk = ~clk;

    predecode_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_is_branch_jump(out_is_branch_jump), .out_is_jump(out_is_jump),
        .out_is_jump_reg(out_is_jump_reg), .out_branch_target(out_branch_target),
        .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
        .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr), .out_rw_addr(out_rw_addr),
        .out_illegal(out_illegal), .count(count)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic bj, input logic j, input logic jr, input logic [31:0] tgt,
                                input logic urs, input logic urt, input logic urw,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.inst = inst; e.bj = bj; e.j = j; e.jr = jr; e.tgt = tgt;
        e.urs = urs; e.urt = urt; e.urw = urw; e.rs = rs; e.rt = rt; e.rw = rw; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every head handed to decode is compared against the oldest expected entry
    always @(negedge clk) begin
        exp_t act;
        exp_t req;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
            act = '{out_pc, out_inst, out_is_branch_jump, out_is_jump, out_is_jump_reg,
                    out_branch_target, out_uses_rs, out_uses_rt, out_uses_rw,
                    out_rs_addr, out_rt_addr, out_rw_addr, out_illegal};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dequeue: got pc=%h inst=%h expected none", out_pc, out_inst);
            end else begin
                req = sb.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL head_entry: got %h expected %h", act, req);
                end
            end
        end
    end

    task automatic enq(input int idx);
        in_valid = 1'b1;
        in_pc    = vec[idx].pc;
        in_inst  = vec[idx].inst;
        @(negedge clk);
        if (in_ready && !flush) sb.push_back(vec[idx]);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        vec[0]  = mk(32'h100,  32'h00221821, 0,0,0, 32'h0,   1,1,1, 5'd1, 5'd2, 5'd3, 0); // addu
        vec[1]  = mk(32'h200,  32'h1022FFFF, 1,0,0, 32'h200, 1,1,0, 5'd1, 5'd2, 5'd0, 0); // beq -1
        vec[2]  = mk(32'h1000, 32'h08000040, 1,1,0, 32'h100, 0,0,0, 5'd0, 5'd0, 5'd0, 0); // j
        vec[3]  = mk(32'h20,   32'h0C000010, 1,1,0, 32'h40,  0,0,1, 5'd0, 5'd0, 5'd31,0); // jal
        vec[4]  = mk(32'h24,   32'h00000000, 0,0,0, 32'h0,   0,0,0, 5'd0, 5'd0, 5'd0, 0); // sll nop
        vec[5]  = mk(32'h28,   32'h00220018, 0,0,0, 32'h0,   0,0,0, 5'd0, 5'd0, 5'd0, 1); // mult
        vec[6]  = mk(32'h2C,   32'hFC000000, 0,0,0, 32'h0,   0,0,0, 5'd0, 5'd0, 5'd0, 1); // op 3F
        vec[7]  = mk(32'h30,   32'h03E00008, 1,1,1, 32'h0,   1,0,0, 5'd31,5'd0, 5'd0, 0); // jr $31
        vec[8]  = mk(32'h34,   32'h8CC50004, 0,0,0, 32'h0,   1,0,1, 5'd6, 5'd0, 5'd5, 0); // lw
        vec[9]  = mk(32'h38,   32'hACC50004, 0,0,0, 32'h0,   1,1,0, 5'd6, 5'd5, 5'd0, 0); // sw
        vec[10] = mk(32'h3C,   32'h00072083, 0,0,0, 32'h0,   1,0,1, 5'd7, 5'd0, 5'd4, 0); // sra
        vec[11] = mk(32'h40,   32'h4089B800, 0,0,0, 32'h0,   0,1,0, 5'd0, 5'd9, 5'd0, 0); // mtc0 rd 0x17
        vec[12] = mk(32'h44,   32'h80000000, 0,0,0, 32'h0,   0,0,0, 5'd0, 5'd0, 5'd0, 1); // lb
        vec[13] = mk(32'h40,   32'h14600002, 1,0,0, 32'h4C,  1,0,0, 5'd3, 5'd0, 5'd0, 0); // bne $3,$0,+2

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        #12;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single addu: visible one cycle after the enqueue
        enq(0);
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_count", 32'(count), 32'd1);
        drain();

        // fill to DEPTH, then a fifth offer must be refused
        enq(1); enq(2); enq(3); enq(4);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        enq(5);
        chk("full_refused_count", 32'(count), 32'd4);

        // take two, then stream with simultaneous enqueue and dequeue across the pointer wrap
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_two_deq_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        enq(5); chk("simul_count_a", 32'(count), 32'd2);
        enq(6); chk("simul_count_b", 32'(count), 32'd2);
        enq(7); chk("simul_count_c", 32'(count), 32'd2);
        drain();

        // remaining predecode vectors streamed with the decoder always ready
        out_ready = 1'b1;
        for (int i = 8; i < 14; i++) enq(i);
        drain();

        // flush together with an offer: entries and the offered instruction are dropped
        enq(0); enq(1); enq(2);
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        enq(3);
        flush = 1'b0;
        sb.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        enq(4);
        drain();

        // asynchronous reset mid-stream
        enq(8); enq(9);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_entry_cleared", out_inst, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        enq(11);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
